// File: rtl/mips_pkg.sv
// Shared types and sizing for the MIPS datapath register file.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned REG_COUNT  = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/mips_register_file.sv
// 32 x 32 register file: two combinational read ports, one falling-edge write port.
// Register 0 reads as zero regardless of its storage contents.
module mips_register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_Ena,
  input  logic [ADDR_WIDTH-1:0] write_Addr,
  input  logic [DATA_WIDTH-1:0] write_Data,
  input  logic [ADDR_WIDTH-1:0] read_Reg_One_Addr,
  input  logic [ADDR_WIDTH-1:0] read_Reg_Two_Addr,
  output logic [DATA_WIDTH-1:0] read_Data_One,
  output logic [DATA_WIDTH-1:0] read_Data_Two
);

  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];

  // Writes land on the falling edge so the same cycle's read sees the new value.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (write_Ena && (write_Addr != '0)) begin
      regs[write_Addr] <= write_Data;
    end
  end

  always_comb begin
    read_Data_One = '0;
    read_Data_Two = '0;
    if (read_Reg_One_Addr != '0) read_Data_One = regs[read_Reg_One_Addr];
    if (read_Reg_Two_Addr != '0) read_Data_Two = regs[read_Reg_Two_Addr];
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: inputs change mid-cycle, outputs checked a period later.
module tb_mips_register_file;

  logic        clk;
  logic        rst;
  logic        write_Ena;
  logic [4:0]  write_Addr;
  logic [31:0] write_Data;
  logic [4:0]  read_Reg_One_Addr;
  logic [4:0]  read_Reg_Two_Addr;
  logic [31:0] read_Data_One;
  logic [31:0] read_Data_Two;

  int checks = 0;
  int errors = 0;

  mips_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .write_Ena         (write_Ena),
    .write_Addr        (write_Addr),
    .write_Data        (write_Data),
    .read_Reg_One_Addr (read_Reg_One_Addr),
    .read_Reg_Two_Addr (read_Reg_Two_Addr),
    .read_Data_One     (read_Data_One),
    .read_Data_Two     (read_Data_Two)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one full period: from one mid-cycle point (posedge+1) past a falling edge to the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    write_Ena         = we;
    write_Addr        = wa;
    write_Data        = wd;
    read_Reg_One_Addr = ra1;
    read_Reg_Two_Addr = ra2;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #1;
    step();
    check("reset_rd0_a", read_Data_One, 32'h0);
    check("reset_rd0_b", read_Data_Two, 32'h0);

    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd5);
    step();
    check("reset_rd3", read_Data_One, 32'h0);
    check("reset_rd5", read_Data_Two, 32'h0);

    // Release reset mid-cycle; attempt to write reg 0.
    rst = 1'b1;
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd3);
    step();
    check("reg0_write_ignored", read_Data_One, 32'h0);
    check("reg3_still_reset", read_Data_Two, 32'h0);

    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 5'd0, 5'd3);
    step();
    drive(1'b1, 5'd1, 32'h8888_8888, 5'd1, 5'd3);
    step();
    check("rd_reg1", read_Data_One, 32'h8888_8888);
    check("rd_reg3", read_Data_Two, 32'hFFFF_FFFF);

    drive(1'b1, 5'd8, 32'h5555_5555, 5'd3, 5'd1);
    step();
    check("swap_rd_reg3", read_Data_One, 32'hFFFF_FFFF);
    check("swap_rd_reg1", read_Data_Two, 32'h8888_8888);

    drive(1'b0, 5'd8, 32'h0, 5'd8, 5'd8);
    step();
    check("rd_reg8_p1", read_Data_One, 32'h5555_5555);
    check("rd_reg8_p2", read_Data_Two, 32'h5555_5555);

    drive(1'b0, 5'd31, 32'h1234_5678, 5'd31, 5'd31);
    step();
    check("we0_reg31_p1", read_Data_One, 32'h0);
    check("we0_reg31_p2", read_Data_Two, 32'h0);

    drive(1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd31);
    step();
    check("we1_reg31_p1", read_Data_One, 32'h1234_5678);
    check("we1_reg31_p2", read_Data_Two, 32'h1234_5678);

    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
    step();
    check("rd_addr0_zero", read_Data_One, 32'h0);
    check("rd_reg8_kept", read_Data_Two, 32'h5555_5555);

    // No bypass: the new value appears only after the falling edge of this cycle.
    drive(1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd1);
    #2;
    check("no_bypass_before_edge", read_Data_One, 32'h0);
    @(negedge clk);
    #1;
    check("visible_after_edge", read_Data_One, 32'hA5A5_A5A5);
    check("other_port_reg1", read_Data_Two, 32'h8888_8888);
    write_Ena = 1'b0;
    step();

    // Asynchronous reset mid-cycle, no clock edge needed.
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd3);
    rst = 1'b0;
    #1;
    check("async_rst_reg1", read_Data_One, 32'h0);
    check("async_rst_reg3", read_Data_Two, 32'h0);
    read_Reg_One_Addr = 5'd8;
    read_Reg_Two_Addr = 5'd31;
    #1;
    check("async_rst_reg8", read_Data_One, 32'h0);
    check("async_rst_reg31", read_Data_Two, 32'h0);

    // Reset dominates a write across a falling edge.
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd5);
    step();
    check("rst_blocks_write", read_Data_One, 32'h0);
    check("rst_clears_reg5", read_Data_Two, 32'h0);

    // First write lands on the first falling edge after release.
    rst = 1'b1;
    step();
    check("first_write_after_release", read_Data_One, 32'hDEAD_BEEF);
    check("reg5_still_clear", read_Data_Two, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
